// File: rtl/alu_sequencer.sv
// alu_sequencer: command front-end for the accumulator ALU.
// Buffers op/operand commands in a small FIFO, issues them to the ALU one at a
// time, holds the ALU between ops and returns the resulting accumulator and
// flags on a valid/ready response channel. Issues a CLEAR after every reset
// because the ALU itself has no reset.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic [3:0]       rsp_flags,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] alu_acc,
  input  logic [3:0]       alu_flags,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    EXEC = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t state;

  // Command FIFO: entries hold {op, data}; count is kept apart from the pointers
  logic [WIDTH+2:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [WIDTH+2:0] head;
  logic [2:0]       head_op;
  logic [WIDTH-1:0] head_data;

  // Full is judged on the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign fifo_empty = (count == {(PW + 1){1'b0}});
  assign cmd_ready  = (count != FULL_COUNT);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign head_op    = head[WIDTH+2:WIDTH];
  assign head_data  = head[WIDTH-1:0];
  assign busy       = (state != IDLE) || !fifo_empty;

  // Pop the head only when the sequencer is free to issue the next op
  always_comb begin
    pop = 1'b0;
    if (state == IDLE) begin
      pop = !fifo_empty;
    end else if (state == RESP) begin
      pop = rsp_ready && !fifo_empty;
    end else begin
      pop = 1'b0;
    end
  end

  // FIFO storage write; contents are made invalid by the count, not cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_data};
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {(PW + 1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM: clear, issue, execute, capture, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      alu_control <= OP_HOLD;
      alu_in      <= {WIDTH{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_acc     <= {WIDTH{1'b0}};
      rsp_flags   <= 4'd0;
    end else begin
      case (state)
        INIT: begin
          alu_control <= OP_CLEAR;
          state       <= IDLE;
        end
        IDLE: begin
          if (pop) begin
            alu_control <= head_op;
            alu_in      <= head_data;
            state       <= EXEC;
          end else begin
            alu_control <= OP_HOLD;
          end
        end
        EXEC: begin
          alu_control <= OP_HOLD;
          state       <= CAPT;
        end
        CAPT: begin
          rsp_acc   <= alu_acc;
          rsp_flags <= alu_flags;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_control <= head_op;
              alu_in      <= head_data;
              state       <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          alu_control <= OP_HOLD;
          rsp_valid   <= 1'b0;
          state       <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural accumulator ALU.
// ALU flags: [0]=zero, [1]=negative, [2]=carry/borrow (ADD/SUB only), [3]=0.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_acc;
  logic [3:0] rsp_flags;
  logic [2:0] alu_control;
  logic [7:0] alu_in;
  logic [7:0] alu_acc;
  logic [3:0] alu_flags;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc), .rsp_flags(rsp_flags),
    .alu_control(alu_control), .alu_in(alu_in), .alu_acc(alu_acc), .alu_flags(alu_flags),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU (no reset, like the real one)
  logic [8:0] alu_res;
  always_comb begin
    case (alu_control)
      3'd1:    alu_res = 9'd0;
      3'd2:    alu_res = {1'b0, alu_acc} + {1'b0, alu_in};
      3'd3:    alu_res = {1'b0, alu_acc} - {1'b0, alu_in};
      3'd4:    alu_res = {1'b0, alu_acc & alu_in};
      3'd5:    alu_res = {1'b0, 8'd0 - alu_acc};
      3'd6:    alu_res = {1'b0, ~alu_acc};
      3'd7:    alu_res = {1'b0, alu_acc ^ alu_in};
      default: alu_res = {1'b0, alu_acc};
    endcase
  end

  always @(posedge clk) begin
    if (alu_control != 3'd0) begin
      alu_acc   <= alu_res[7:0];
      alu_flags <= {1'b0,
                    ((alu_control == 3'd2) || (alu_control == 3'd3)) ? alu_res[8] : 1'b0,
                    alu_res[7],
                    (alu_res[7:0] == 8'd0)};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command and hold it until accepted; returns on the negedge after acceptance
  task automatic push(input logic [2:0] op, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", {31'd0, (n >= 50)}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response (rsp_ready assumed high), check it, step past the handshake
  task automatic get_rsp(input string tag, input logic [7:0] ea, input logic [3:0] ef, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'd0, (n >= 50)}, 32'd0);
    check({tag, "_acc"}, {24'd0, rsp_acc}, {24'd0, ea});
    check({tag, "_flags"}, {28'd0, rsp_flags}, {28'd0, ef});
    lat = n;
    @(negedge clk);
  endtask

  // Release reset and check the one-cycle CLEAR that follows
  task automatic release_and_check_clear(input string tag);
    rst = 1'b0;
    check({tag, "_init_ctrl"}, {29'd0, alu_control}, 32'd0);
    check({tag, "_init_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_clear_ctrl"}, {29'd0, alu_control}, 32'd1);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check({tag, "_hold_ctrl"}, {29'd0, alu_control}, 32'd0);
  endtask

  logic [7:0] e_acc [5];
  logic [3:0] e_flg [5];

  initial begin
    int lat;
    int n;
    int got;
    int acc_iter;
    bit pend;
    bit accepted5;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
    rsp_ready = 1'b1;

    // 1: reset values, then CLEAR for exactly one cycle
    repeat (3) @(negedge clk);
    check("rst_alu_control", {29'd0, alu_control}, 32'd0);
    check("rst_alu_in", {24'd0, alu_in}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_acc", {24'd0, rsp_acc}, 32'd0);
    check("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    release_and_check_clear("t1");

    // 2: back-to-back commands, responses in order
    push(3'd2, 8'h05);
    push(3'd3, 8'h03);
    push(3'd7, 8'h09);
    get_rsp("t2_add", 8'h05, 4'b0000, lat);
    get_rsp("t2_sub", 8'h02, 4'b0000, lat);
    get_rsp("t2_xor", 8'h0B, 4'b0000, lat);

    // 3/4: stalled response, FIFO fills, rsp_* stable, ALU held
    rsp_ready = 1'b0;
    push(3'd3, 8'h0C);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_a_timeout", {31'd0, (n >= 50)}, 32'd0);
    check("t3_a_acc", {24'd0, rsp_acc}, 32'h0000_00FF);
    check("t3_a_flags", {28'd0, rsp_flags}, 32'h0000_0006);

    e_acc[0] = 8'h00; e_flg[0] = 4'b0101;
    e_acc[1] = 8'h00; e_flg[1] = 4'b0001;
    e_acc[2] = 8'h80; e_flg[2] = 4'b0010;
    e_acc[3] = 8'h80; e_flg[3] = 4'b0010;
    e_acc[4] = 8'h7F; e_flg[4] = 4'b0000;

    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'h01;
    check("t3_ready0", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_op = 3'd4; cmd_data = 8'h00;
    check("t3_ready1", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_op = 3'd2; cmd_data = 8'h80;
    check("t3_ready2", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_op = 3'd5; cmd_data = 8'h00;
    check("t3_ready3", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_op = 3'd7; cmd_data = 8'hFF;
    check("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("t4_rsp_acc", {24'd0, rsp_acc}, 32'h0000_00FF);
      check("t4_rsp_flags", {28'd0, rsp_flags}, 32'h0000_0006);
      check("t4_alu_control", {29'd0, alu_control}, 32'd0);
      check("t4_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end

    rsp_ready = 1'b1;
    got = 0; n = 0; pend = 1'b0; accepted5 = 1'b0; acc_iter = -1;
    while (got < 5 && n < 80) begin
      @(negedge clk);
      n++;
      if (pend) begin
        cmd_valid = 1'b0;
        pend      = 1'b0;
        accepted5 = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        pend     = 1'b1;
        acc_iter = n;
      end
      if (rsp_valid) begin
        check("t3_order_acc", {24'd0, rsp_acc}, {24'd0, e_acc[got]});
        check("t3_order_flags", {28'd0, rsp_flags}, {28'd0, e_flg[got]});
        got++;
      end
    end
    cmd_valid = 1'b0;
    check("t3_rsp_count", got, 32'd5);
    check("t3_fifth_accepted", {31'd0, accepted5}, 32'd1);
    check("t3_fifth_accept_cycle", acc_iter, 32'd1);
    @(negedge clk);

    // 5: HOLD reads back the accumulator unchanged, then NOT
    push(3'd1, 8'h00);
    get_rsp("t5_clear", 8'h00, 4'b0001, lat);
    push(3'd2, 8'h05);
    get_rsp("t5_add", 8'h05, 4'b0000, lat);
    check("t5_latency", lat, 32'd3);
    push(3'd0, 8'h33);
    get_rsp("t5_hold", 8'h05, 4'b0000, lat);
    push(3'd6, 8'h00);
    get_rsp("t5_not", 8'hFA, 4'b0010, lat);

    // 6: reset during EXEC of ADD 7 with a further command queued
    push(3'd2, 8'h07);
    push(3'd7, 8'h01);
    n = 0;
    while (alu_control != 3'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_exec_timeout", {31'd0, (n >= 20)}, 32'd0);
    rst = 1'b1;
    #1;
    check("t6_async_ctrl", {29'd0, alu_control}, 32'd0);
    check("t6_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    release_and_check_clear("t6");
    repeat (6) @(negedge clk);
    check("t6_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    check("t6_fifo_empty", {31'd0, busy}, 32'd0);
    push(3'd2, 8'h07);
    get_rsp("t6_add", 8'h07, 4'b0000, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
